// File: rtl/fp_divide_iterative_if.sv
// fp_divide_iterative handshake bundle and rounding encodings.
// Master drives operands; slave returns the result and flags.
package fp_pkg;
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
endpackage

interface fp_divide_iterative_if;
  logic        valid_data_in;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [2:0]  rounding_mode;
  logic        ready;
  logic [31:0] out;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        invalid_operation;
  logic        divide_by_zero;
  logic        valid_data_out;

  modport master (
    output valid_data_in, in1, in2, rounding_mode,
    input  ready, out, overflow, underflow, inexact,
    input  invalid_operation, divide_by_zero, valid_data_out
  );

  modport slave (
    input  valid_data_in, in1, in2, rounding_mode,
    output ready, out, overflow, underflow, inexact,
    output invalid_operation, divide_by_zero, valid_data_out
  );
endinterface

// File: rtl/fp_divide_iterative.sv
// Single-precision divider, radix-2 restoring, one op in flight.
// Denormals flush to zero; specials bypass the iteration.
module fp_divide_iterative
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp_divide_iterative_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_t;
  state_t state_q, state_d;

  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        z1, z2, i1, i2, qn1, qn2, sn1, sn2, d1, d2;
  logic        sgn, acc;

  assign e1  = bus.in1[30:23];
  assign e2  = bus.in2[30:23];
  assign m1  = bus.in1[22:0];
  assign m2  = bus.in2[22:0];
  assign z1  = e1 == 8'h00;
  assign z2  = e2 == 8'h00;
  assign d1  = z1 & (m1 != 23'd0);
  assign d2  = z2 & (m2 != 23'd0);
  assign i1  = (e1 == 8'hFF) & (m1 == 23'd0);
  assign i2  = (e2 == 8'hFF) & (m2 == 23'd0);
  assign qn1 = (e1 == 8'hFF) & m1[22];
  assign qn2 = (e2 == 8'hFF) & m2[22];
  assign sn1 = (e1 == 8'hFF) & ~m1[22] & (m1 != 23'd0);
  assign sn2 = (e2 == 8'hFF) & ~m2[22] & (m2 != 23'd0);
  assign sgn = bus.in1[31] ^ bus.in2[31];
  assign acc = bus.valid_data_in & (state_q == IDLE);

  logic        sp, sp_inv, sp_dbz;
  logic [31:0] sp_res;

  always_comb begin
    sp     = 1'b1;
    sp_res = 32'd0;
    sp_inv = 1'b0;
    sp_dbz = 1'b0;
    if (qn1) sp_res = bus.in1;
    else if (qn2) sp_res = bus.in2;
    else if (sn1 | sn2) begin
      sp_res = (sn1 ? bus.in1 : bus.in2) | 32'h0040_0000;
      sp_inv = 1'b1;
    end else if ((z1 & z2) | (i1 & i2)) begin
      sp_res = 32'h7FC0_0000;
      sp_inv = 1'b1;
    end else if (i1) sp_res = {sgn, 31'h7F80_0000};
    else if (z2) begin
      sp_res = {sgn, 31'h7F80_0000};
      sp_dbz = 1'b1;
    end else if (i2 | z1) sp_res = {sgn, 31'd0};
    else sp = 1'b0;
  end

  logic               sign_q, den_q, is_sp_q, inv_q, dbz_q;
  logic [2:0]         rm_q;
  logic signed [9:0]  exp_q;
  logic [24:0]        rem_q;
  logic [23:0]        div_q;
  logic [26:0]        q_q;
  logic [4:0]         cnt_q;
  logic [31:0]        sp_res_q;

  logic        ge;
  logic [24:0] rem_sub;
  assign ge      = rem_q >= {1'b0, div_q};
  assign rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;

  logic              norm, g, r, s, up;
  logic [22:0]       mant;
  logic [23:0]       sum;
  logic signed [9:0] exp_r;
  logic              ovf, unf;
  logic [31:0]       ovf_res;

  assign norm  = q_q[26];
  assign mant  = norm ? q_q[25:3] : q_q[24:2];
  assign g     = norm ? q_q[2] : q_q[1];
  assign r     = norm ? q_q[1] : q_q[0];
  assign s     = (norm & q_q[0]) | (rem_q != 25'd0);
  assign sum   = {1'b0, mant} + {23'd0, up};
  assign exp_r = exp_q - {9'd0, ~norm} + {9'd0, sum[23]};
  assign ovf   = exp_r > 10'sd254;
  assign unf   = exp_r <= 10'sd0;

  always_comb begin
    up = 1'b0;
    unique case (rm_q)
      RNE:     up = g & (r | s | mant[0]);
      RDN:     up = sign_q & (g | r | s);
      RUP:     up = ~sign_q & (g | r | s);
      RMM:     up = g;
      default: up = 1'b0;
    endcase
  end

  always_comb begin
    ovf_res = {sign_q, 31'h7F80_0000};
    unique case (rm_q)
      RTZ:     ovf_res = {sign_q, 31'h7F7F_FFFF};
      RDN:     ovf_res = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
      RUP:     ovf_res = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
      default: ovf_res = {sign_q, 31'h7F80_0000};
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = sp ? ROUND : DIVIDE;
      DIVIDE:  if (cnt_q == 5'd0) state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic [31:0] out_q;
  logic        ovf_q, unf_q, inx_q, inv_o_q, dbz_o_q, vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      den_q    <= 1'b0;
      is_sp_q  <= 1'b0;
      inv_q    <= 1'b0;
      dbz_q    <= 1'b0;
      rm_q     <= 3'd0;
      exp_q    <= 10'sd0;
      rem_q    <= 25'd0;
      div_q    <= 24'd0;
      q_q      <= 27'd0;
      cnt_q    <= 5'd0;
      sp_res_q <= 32'd0;
      out_q    <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      inv_o_q  <= 1'b0;
      dbz_o_q  <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: if (acc) begin
          sign_q   <= sgn;
          rm_q     <= (bus.rounding_mode > RMM) ? RTZ : bus.rounding_mode;
          exp_q    <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
          rem_q    <= {2'b01, m1};
          div_q    <= {1'b1, m2};
          q_q      <= 27'd0;
          cnt_q    <= 5'd26;
          den_q    <= d1 | d2;
          is_sp_q  <= sp;
          sp_res_q <= sp_res;
          inv_q    <= sp_inv;
          dbz_q    <= sp_dbz;
        end
        DIVIDE: begin
          rem_q <= {rem_sub[23:0], 1'b0};
          q_q   <= {q_q[25:0], ge};
          cnt_q <= cnt_q - 5'd1;
        end
        ROUND: begin
          vld_q   <= 1'b1;
          inv_o_q <= is_sp_q & inv_q;
          dbz_o_q <= is_sp_q & dbz_q;
          if (is_sp_q) begin
            out_q <= sp_res_q;
            ovf_q <= 1'b0;
            unf_q <= den_q;
            inx_q <= 1'b0;
          end else if (ovf) begin
            out_q <= ovf_res;
            ovf_q <= 1'b1;
            unf_q <= 1'b0;
            inx_q <= 1'b1;
          end else if (unf) begin
            out_q <= {sign_q, 31'd0};
            ovf_q <= 1'b0;
            unf_q <= 1'b1;
            inx_q <= 1'b1;
          end else begin
            out_q <= {sign_q, exp_r[7:0], sum[22:0]};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= g | r | s | den_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready             = state_q == IDLE;
  assign bus.out               = out_q;
  assign bus.overflow          = ovf_q;
  assign bus.underflow         = unf_q;
  assign bus.inexact           = inx_q;
  assign bus.invalid_operation = inv_o_q;
  assign bus.divide_by_zero    = dbz_o_q;
  assign bus.valid_data_out    = vld_q;

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Directed bench for fp_divide_iterative.
// Flags are packed {ovf,unf,inx,inv,dbz}.
module tb_fp_divide_iterative;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fp_divide_iterative_if bus ();

  fp_divide_iterative dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] r_out;
  logic [4:0]  r_flg;
  int          r_lat;
  logic        r_one;

  function automatic logic [4:0] flags();
    return {bus.overflow, bus.underflow, bus.inexact,
            bus.invalid_operation, bus.divide_by_zero};
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.valid_data_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    r_lat = bus.valid_data_out ? n : -1;
    r_out = bus.out;
    r_flg = flags();
    @(negedge clk);
    r_one = !bus.valid_data_out;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] rm);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.valid_data_in = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.rounding_mode = rm;
    @(negedge clk);
    bus.valid_data_in = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ready, bus.valid_data_out, bus.out, flags()} !== {2'b10, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b out=%h flg=%b want rdy=1 vld=0 out=0 flg=0",
               bus.ready, bus.valid_data_out, bus.out, flags());
    end
  endtask

  task automatic test_basic();
    run(32'h40C00000, 32'h40000000, 3'b000);
    checks++;
    if ({r_out, r_flg} !== {32'h40400000, 5'b00000}) begin
      errors++;
      $display("FAIL basic got %h/%b want 40400000/00000", r_out, r_flg);
    end
    checks++;
    if (r_lat !== 28) begin
      errors++;
      $display("FAIL basic_latency got %0d want 28", r_lat);
    end
    checks++;
    if (r_one !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_width got %b want 1 (single cycle)", r_one);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] a  [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
    logic [2:0]  rm [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] ex [4] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB};
    for (int i = 0; i < 4; i++) begin
      run(a[i], 32'h40400000, rm[i]);
      checks++;
      if ({r_out, r_flg} !== {ex[i], 5'b00100}) begin
        errors++;
        $display("FAIL round_%0d got %h/%b want %h/00100", i, r_out, r_flg, ex[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] a  [4] = '{32'h3F800000, 32'h00000000, 32'h7F800001, 32'h00400000};
    logic [31:0] b  [4] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] ex [4] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00001, 32'h00000000};
    logic [4:0]  ef [4] = '{5'b00001, 5'b00010, 5'b00010, 5'b01000};
    for (int i = 0; i < 4; i++) begin
      run(a[i], b[i], 3'b000);
      checks++;
      if ({r_out, r_flg} !== {ex[i], ef[i]}) begin
        errors++;
        $display("FAIL special_%0d got %h/%b want %h/%b", i, r_out, r_flg, ex[i], ef[i]);
      end
      checks++;
      if (r_lat !== 1) begin
        errors++;
        $display("FAIL special_lat_%0d got %0d want 1", i, r_lat);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a  [3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF};
    logic [2:0]  rm [3] = '{3'b000, 3'b001, 3'b011};
    logic [31:0] ex [3] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
    for (int i = 0; i < 3; i++) begin
      run(a[i], 32'h3F000000, rm[i]);
      checks++;
      if ({r_out, r_flg} !== {ex[i], 5'b10100}) begin
        errors++;
        $display("FAIL overflow_%0d got %h/%b want %h/10100", i, r_out, r_flg, ex[i]);
      end
    end
  endtask

  task automatic test_underflow();
    run(32'h00800000, 32'h40000000, 3'b000);
    checks++;
    if ({r_out, r_flg} !== {32'h00000000, 5'b01100}) begin
      errors++;
      $display("FAIL underflow got %h/%b want 00000000/01100", r_out, r_flg);
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    bus.valid_data_in = 1'b1;
    bus.in1 = 32'h40C00000;
    bus.in2 = 32'h40000000;
    bus.rounding_mode = 3'b000;
    @(negedge clk);
    bus.valid_data_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.valid_data_in = 1'b1;
    bus.in1 = 32'h3F800000;
    bus.in2 = 32'h40400000;
    bus.rounding_mode = 3'b011;
    @(negedge clk);
    bus.valid_data_in = 1'b0;
    wait_done();
    checks++;
    if ({r_out, r_flg} !== {32'h40400000, 5'b00000}) begin
      errors++;
      $display("FAIL ignore got %h/%b want 40400000/00000", r_out, r_flg);
    end
    checks++;
    if (r_lat !== 23) begin
      errors++;
      $display("FAIL ignore_latency got %0d want 23 after stray pulse", r_lat);
    end
  endtask

  task automatic test_abort();
    logic seen;
    @(negedge clk);
    bus.valid_data_in = 1'b1;
    bus.in1 = 32'h3F800000;
    bus.in2 = 32'h40400000;
    bus.rounding_mode = 3'b000;
    @(negedge clk);
    bus.valid_data_in = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.valid_data_out, bus.out, flags()} !== {2'b10, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL abort_reset got rdy=%b vld=%b out=%h flg=%b want 1/0/0/0",
               bus.ready, bus.valid_data_out, bus.out, flags());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_data_out) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_pulse got pulse=%b want 0", seen);
    end
    run(32'h3F800000, 32'h40400000, 3'b000);
    checks++;
    if ({r_out, r_flg, r_lat} !== {32'h3EAAAAAB, 5'b00100, 32'd28}) begin
      errors++;
      $display("FAIL after_abort got %h/%b lat=%0d want 3EAAAAAB/00100 lat=28",
               r_out, r_flg, r_lat);
    end
  endtask

  initial begin
    bus.valid_data_in = 1'b0;
    bus.in1 = 32'd0;
    bus.in2 = 32'd0;
    bus.rounding_mode = 3'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_rounding();
    test_special();
    test_overflow();
    test_underflow();
    test_ignore();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
